bus_resp_checker: RTL

Synthesizable response checker for the bus-signal test path. The stimulus side pushes expected 4-bit responses and the DUT-output side presents observed responses. The block queues the expected values, compares each observed value in order, and counts matches and errors. It captures the first mismatch and reports pass/fail after a programmed transaction count.

---
 rtl/bus_resp_checker.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_resp_checker.sv
// Response checker: queues expected responses, compares observed responses in order,
// counts matches/errors, captures the first error and reports pass after num_txn compares.
module bus_resp_checker #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              sim_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_txn,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_obs,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   FCNT_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   FCNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    fifo_cnt_r;
  logic [PTR_W:0]    fifo_cnt_nxt_s;

  logic [CNT_W-1:0]  cmp_idx_r;
  logic [CNT_W-1:0]  target_r;
  logic [CNT_W-1:0]  match_cnt_r;
  logic [CNT_W-1:0]  err_cnt_r;
  logic [CNT_W-1:0]  first_err_idx_r;
  logic [DATA_W-1:0] first_err_exp_r;
  logic [DATA_W-1:0] first_err_obs_r;
  logic              have_err_r;
  logic              underflow_r;

  logic              busy_s;
  logic              start_ok_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              cmp_s;
  logic              pop_s;
  logic              last_cmp_s;
  logic              cmp_err_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] err_exp_s;

  assign busy_s       = (state_r == ST_RUN);
  assign start_ok_s   = start && (state_r != ST_RUN);
  assign fifo_empty_s = (fifo_cnt_r == FCNT_ZERO);
  // Ready comes only from the registered count, so a pop never frees a slot in the same cycle.
  assign push_s       = busy_s && exp_valid && (fifo_cnt_r < FIFO_FULL);
  assign cmp_s        = busy_s && obs_valid;
  assign pop_s        = cmp_s && !fifo_empty_s;
  assign last_cmp_s   = cmp_s && (cmp_idx_r == (target_r - CNT_ONE));
  assign head_s       = mem_r[rd_ptr_r];
  assign err_exp_s    = fifo_empty_s ? DATA_ZERO : head_s;
  assign cmp_err_s    = cmp_s && (fifo_empty_s || (head_s != obs_data));

  // Next-state selection for the run controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = (num_txn == CNT_ZERO) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (last_cmp_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Occupancy update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_r;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + FCNT_ONE;
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - FCNT_ONE;
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Run controller state register.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Expected-value storage; contents are don't-care once pointers are cleared.
  always_ff @(posedge sim_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= exp_data;
    end
  end

  // FIFO pointers and occupancy; an accepted start empties the queue.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      fifo_cnt_r <= FCNT_ZERO;
    end else if (start_ok_s) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      fifo_cnt_r <= FCNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
    end
  end

  // Comparison bookkeeping: counters, sticky underflow and first-error capture.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      cmp_idx_r       <= CNT_ZERO;
      target_r        <= CNT_ZERO;
      match_cnt_r     <= CNT_ZERO;
      err_cnt_r       <= CNT_ZERO;
      first_err_idx_r <= CNT_ZERO;
      first_err_exp_r <= DATA_ZERO;
      first_err_obs_r <= DATA_ZERO;
      have_err_r      <= 1'b0;
      underflow_r     <= 1'b0;
    end else if (start_ok_s) begin
      cmp_idx_r       <= CNT_ZERO;
      target_r        <= num_txn;
      match_cnt_r     <= CNT_ZERO;
      err_cnt_r       <= CNT_ZERO;
      first_err_idx_r <= CNT_ZERO;
      first_err_exp_r <= DATA_ZERO;
      first_err_obs_r <= DATA_ZERO;
      have_err_r      <= 1'b0;
      underflow_r     <= 1'b0;
    end else if (cmp_s) begin
      cmp_idx_r <= cmp_idx_r + CNT_ONE;
      if (fifo_empty_s) begin
        underflow_r <= 1'b1;
      end
      if (cmp_err_s) begin
        if (err_cnt_r != CNT_MAX) begin
          err_cnt_r <= err_cnt_r + CNT_ONE;
        end
        if (!have_err_r) begin
          have_err_r      <= 1'b1;
          first_err_idx_r <= cmp_idx_r;
          first_err_exp_r <= err_exp_s;
          first_err_obs_r <= obs_data;
        end
      end else begin
        match_cnt_r <= match_cnt_r + CNT_ONE;
      end
    end
  end

  assign exp_ready     = busy_s && (fifo_cnt_r < FIFO_FULL);
  assign busy          = busy_s;
  assign done          = (state_r == ST_DONE);
  // Leftover expected entries at the end of a run count as a failure.
  assign pass          = (state_r == ST_DONE) && (err_cnt_r == CNT_ZERO) &&
                         !underflow_r && (fifo_cnt_r == FCNT_ZERO);
  assign match_cnt     = match_cnt_r;
  assign err_cnt       = err_cnt_r;
  assign first_err_idx = first_err_idx_r;
  assign first_err_exp = first_err_exp_r;
  assign first_err_obs = first_err_obs_r;
  assign underflow     = underflow_r;

endmodule
